// File: rtl/fft_r2_dif.sv
// ==== fft_r2_dif : serial-in/serial-out radix-2 DIF FFT, N = 2**POW, one butterfly per clock ====
// ==== define FFT_STAGE_SCALE_EN to halve every butterfly output (output = DFT/N) ; rev 1.0 ====
`default_nettype none

module fft_r2_dif #(
  parameter int DATA_WIDTH = 16,
  parameter int POW        = 4,
  parameter int TW_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] sink_r,
  input  logic signed [DATA_WIDTH-1:0] sink_i,
  output logic signed [DATA_WIDTH-1:0] source_r,
  output logic signed [DATA_WIDTH-1:0] source_i,
  output logic                         valid_out,
  output logic                         busy
);

  localparam int N    = 1 << POW;
  localparam int HW   = POW - 1;
  localparam int SW   = $clog2(POW);
  localparam int FRAC = TW_WIDTH - 2;
  localparam int DW1  = DATA_WIDTH + 1;
  localparam int PW   = DATA_WIDTH + TW_WIDTH + 2;
`ifdef FFT_STAGE_SCALE_EN
  localparam int SHIFT = FRAC + 1;
`else
  localparam int SHIFT = FRAC;
`endif

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [POW-1:0] ONE_P      = POW'(1);
  localparam logic [SW-1:0]  STAGE_LAST = SW'(POW - 1);

  logic [1:0]     state, state_nxt;
  logic [POW-1:0] cnt;
  logic [HW-1:0]  bfly;
  logic [SW-1:0]  stage;
  logic           load_en, calc_en, out_en;
  logic           cnt_last, bfly_last, stage_last;

  logic signed [DATA_WIDTH-1:0] mem_r [N];
  logic signed [DATA_WIDTH-1:0] mem_i [N];

  // Twiddle ROM: W^i = cos - j*sin for i in [0, N/2), rounded to nearest
  function automatic logic signed [TW_WIDTH-1:0] tw_q(input int idx, input bit sin_part);
    real ang, v;
    int  q;
    ang = 2.0 * 3.14159265358979323846 * $itor(idx) / $itor(N);
    v   = (sin_part ? -$sin(ang) : $cos(ang)) * $itor(1 << FRAC);
    q   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return TW_WIDTH'(q);
  endfunction

  logic signed [TW_WIDTH-1:0] tw_re [N/2];
  logic signed [TW_WIDTH-1:0] tw_im [N/2];

  generate
    for (genvar gi = 0; gi < N/2; gi++) begin : g_tw
      localparam logic signed [TW_WIDTH-1:0] W_RE = tw_q(gi, 1'b0);
      localparam logic signed [TW_WIDTH-1:0] W_IM = tw_q(gi, 1'b1);
      assign tw_re[gi] = W_RE;
      assign tw_im[gi] = W_IM;
    end
  endgenerate

  function automatic logic [POW-1:0] bitrev(input logic [POW-1:0] v);
    logic [POW-1:0] r;
    for (int i = 0; i < POW; i++) r[i] = v[POW-1-i];
    return r;
  endfunction

  assign cnt_last   = (cnt == {POW{1'b1}});
  assign bfly_last  = (bfly == {HW{1'b1}});
  assign stage_last = (stage == STAGE_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (valid_in && cnt_last)     state_nxt = S_CALC;
      S_CALC:  if (bfly_last && stage_last)  state_nxt = S_OUT;
      S_OUT:   if (cnt_last)                 state_nxt = S_LOAD;
      default:                               state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    load_en = 1'b0;
    calc_en = 1'b0;
    out_en  = 1'b0;
    case (state)
      S_LOAD: load_en = valid_in;
      S_CALC: begin busy = 1'b1; calc_en = 1'b1; end
      S_OUT:  begin busy = 1'b1; out_en  = 1'b1; end
      default: ;
    endcase
  end

  // Butterfly addresses: p is the butterfly index with a 0 inserted at bit (POW-1-stage)
  logic [POW-1:0] jx, half_m, k_idx, p_idx, q_idx;
  logic [HW-1:0]  tw_idx;
  int             shamt;

  always_comb begin
    shamt  = HW - int'(stage);
    jx     = {1'b0, bfly};
    half_m = ONE_P << shamt;
    k_idx  = jx & (half_m - ONE_P);
    p_idx  = ((jx >> shamt) << (shamt + 1)) | k_idx;
    q_idx  = p_idx | half_m;
    tw_idx = HW'(k_idx << stage);
  end

  logic signed [DW1-1:0]        sum_r, sum_i, dif_r, dif_i;
  logic signed [PW-1:0]         prd_r, prd_i;
  logic signed [DATA_WIDTH-1:0] new_p_r, new_p_i, new_q_r, new_q_i;
  logic                         unused_bits;

  always_comb begin
    sum_r = DW1'(mem_r[p_idx]) + DW1'(mem_r[q_idx]);
    sum_i = DW1'(mem_i[p_idx]) + DW1'(mem_i[q_idx]);
    dif_r = DW1'(mem_r[p_idx]) - DW1'(mem_r[q_idx]);
    dif_i = DW1'(mem_i[p_idx]) - DW1'(mem_i[q_idx]);
    prd_r = PW'(dif_r) * PW'(tw_re[tw_idx]) - PW'(dif_i) * PW'(tw_im[tw_idx]);
    prd_i = PW'(dif_r) * PW'(tw_im[tw_idx]) + PW'(dif_i) * PW'(tw_re[tw_idx]);
    // Bit slicing = arithmetic shift (floor) followed by two's-complement wrap
    new_q_r = prd_r[SHIFT+DATA_WIDTH-1:SHIFT];
    new_q_i = prd_i[SHIFT+DATA_WIDTH-1:SHIFT];
`ifdef FFT_STAGE_SCALE_EN
    new_p_r = sum_r[DATA_WIDTH:1];
    new_p_i = sum_i[DATA_WIDTH:1];
`else
    new_p_r = sum_r[DATA_WIDTH-1:0];
    new_p_i = sum_i[DATA_WIDTH-1:0];
`endif
  end

  assign unused_bits = ^{prd_r, prd_i, sum_r, sum_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bfly      <= '0;
      stage     <= '0;
      source_r  <= '0;
      source_i  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= out_en;
      if (load_en) cnt <= cnt + ONE_P;
      if (calc_en) begin
        bfly <= bfly + HW'(1);
        if (bfly_last) stage <= stage_last ? '0 : stage + SW'(1);
      end
      if (out_en) begin
        source_r <= mem_r[bitrev(cnt)];
        source_i <= mem_i[bitrev(cnt)];
        cnt      <= cnt + ONE_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[cnt] <= sink_r;
      mem_i[cnt] <= sink_i;
    end else if (calc_en) begin
      mem_r[p_idx] <= new_p_r;
      mem_i[p_idx] <= new_p_i;
      mem_r[q_idx] <= new_q_r;
      mem_i[q_idx] <= new_q_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_r2_dif.sv
// ==== tb_fft_r2_dif : scoreboard bench for fft_r2_dif (fixed-point reference model + exact-value spot checks) ====
// ==== rev 1.0 ====
`default_nettype none

module tb_fft_r2_dif;

  localparam int DW  = 16;
  localparam int POW = 4;
  localparam int TW  = 16;
  localparam int N   = 1 << POW;
  localparam int LAT = POW * N / 2 + 1;
  localparam int PER = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] sink_r = '0;
  logic signed [DW-1:0] sink_i = '0;
  logic signed [DW-1:0] source_r, source_i;
  logic                 valid_out, busy;

  fft_r2_dif #(.DATA_WIDTH(DW), .POW(POW), .TW_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .sink_r(sink_r), .sink_i(sink_i),
    .source_r(source_r), .source_i(source_i),
    .valid_out(valid_out), .busy(busy)
  );

  always #(PER/2) clk = ~clk;

  typedef struct { int re; int im; } exp_t;
  exp_t   sb_q[$];
  exp_t   e_mon;
  int     n_vec = 0, n_err = 0;
  int     in_r[N], in_i[N], mr[N], mi[N], got_r[N], got_i[N];
  int     bursts = 0, run = 0;
  bit     prev_v = 1'b0;
  longint t_first = 0, t_last = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap(input longint v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return int'(t);
  endfunction

  function automatic int twq(input int idx, input bit sin_part);
    real a, v;
    a = 2.0 * 3.14159265358979323846 * $itor(idx) / $itor(N);
    v = (sin_part ? -$sin(a) : $cos(a)) * $itor(1 << (TW - 2));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < POW; b++) if (v[b]) r |= 1 << (POW - 1 - b);
    return r;
  endfunction

  // Reference: textbook group/k loop over stages, spec arithmetic, natural-order push
  task automatic run_model_push;
    int     half, p, q, wr, wi;
    longint sr, si, dr, di, pr, pim;
    exp_t   e;
    for (int n = 0; n < N; n++) begin mr[n] = in_r[n]; mi[n] = in_i[n]; end
    for (int s = 0; s < POW; s++) begin
      half = N >> (s + 1);
      for (int g = 0; g < N; g += 2 * half) begin
        for (int k = 0; k < half; k++) begin
          p   = g + k;
          q   = p + half;
          sr  = longint'(mr[p]) + mr[q];
          si  = longint'(mi[p]) + mi[q];
          dr  = longint'(mr[p]) - mr[q];
          di  = longint'(mi[p]) - mi[q];
          wr  = twq(k << s, 1'b0);
          wi  = twq(k << s, 1'b1);
          pr  = (dr * wr - di * wi) >>> (TW - 2);
          pim = (dr * wi + di * wr) >>> (TW - 2);
`ifdef FFT_STAGE_SCALE_EN
          sr = sr >>> 1;  si  = si >>> 1;
          pr = pr >>> 1;  pim = pim >>> 1;
`endif
          mr[p] = wrap(sr);  mi[p] = wrap(si);
          mr[q] = wrap(pr);  mi[q] = wrap(pim);
        end
      end
    end
    for (int m = 0; m < N; m++) begin
      e.re = mr[brev(m)];
      e.im = mi[brev(m)];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_free(input bit junk);
    int g = 0;
    while (busy && g < 8 * N * POW) begin
      valid_in = junk;
      sink_r   = 16'sh7FFF;
      sink_i   = 16'sh7FFF;
      step;
      g++;
    end
    check_val("free_in_time", int'(busy), 0);
  endtask

  task automatic send_frame(input int gap, input bit junk);
    for (int i = 0; i < N; i++) begin
      wait_free(junk);
      if (i > 0) begin
        valid_in = 1'b0;
        repeat (gap) step;
      end
      valid_in = 1'b1;
      sink_r   = DW'(in_r[i]);
      sink_i   = DW'(in_i[i]);
      step;
      t_last = $time - 1;
    end
    valid_in = 1'b0;
    run_model_push;
  endtask

  task automatic wait_bursts(input int target);
    int g = 0;
    while (bursts < target && g < 12 * N * POW) begin
      step;
      g++;
    end
    check_val("burst_seen", int'(bursts >= target), 1);
  endtask

  task automatic check_reset_state;
    check_val("rst_source_r", int'(source_r), 0);
    check_val("rst_source_i", int'(source_i), 0);
    check_val("rst_valid_out", int'(valid_out), 0);
    check_val("rst_busy", int'(busy), 0);
  endtask

  task automatic set_impulse;
    for (int i = 0; i < N; i++) begin in_r[i] = 0; in_i[i] = 0; end
    in_r[0] = 1000;
  endtask

  task automatic set_dc;
    for (int i = 0; i < N; i++) begin in_r[i] = 100; in_i[i] = 0; end
  endtask

  task automatic set_seq;
    int seq [8] = '{12, 49, 2, 48, 70, 13, 5, 6};
    for (int i = 0; i < N; i++) begin
      in_r[i] = (i < 8) ? seq[i] : 0;
      in_i[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      run    = 0;
    end else begin
      if (valid_out) begin
        if (!prev_v) begin
          t_first = $time - PER/2;
          run     = 0;
        end
        check_val("sb_avail", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e_mon = sb_q.pop_front();
          check_val($sformatf("bin%0d_re", run), int'(source_r), e_mon.re);
          check_val($sformatf("bin%0d_im", run), int'(source_i), e_mon.im);
        end
        if (run < N) begin
          got_r[run] = int'(source_r);
          got_i[run] = int'(source_i);
        end
        run++;
      end else if (prev_v) begin
        check_val("burst_len", run, N);
        bursts++;
      end
      prev_v = valid_out;
    end
  end

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step; step;
    check_reset_state;
    rst = 1'b0;

    // Partial frame aborted by reset
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      sink_r   = DW'(7000 + i);
      sink_i   = -16'sd300;
      step;
    end
    valid_in = 1'b0;
    rst = 1'b1;
    step; step;
    check_reset_state;
    rst = 1'b0;

    set_impulse;
    send_frame(0, 1'b0);
    wait_bursts(1);
    check_val("impulse_latency", int'((t_first - t_last) / PER), LAT);
    check_val("bursts_after_abort", bursts, 1);
`ifndef FFT_STAGE_SCALE_EN
    for (int m = 0; m < N; m++) begin
      check_val($sformatf("imp_const%0d_re", m), got_r[m], 1000);
      check_val($sformatf("imp_const%0d_im", m), got_i[m], 0);
    end
`endif

    set_dc;
    send_frame(0, 1'b0);
    wait_bursts(2);
`ifdef FFT_STAGE_SCALE_EN
    check_val("dc_x0_scaled", got_r[0], 100);
`else
    check_val("dc_x0", got_r[0], 1600);
`endif
    check_val("dc_x1", got_r[1], 0);
    check_val("dc_x15", got_r[N-1], 0);

    set_seq;
    send_frame(0, 1'b0);
    wait_bursts(3);
`ifndef FFT_STAGE_SCALE_EN
    check_val("seq_x0_re", got_r[0], 205);
    check_val("seq_x0_im", got_i[0], 0);
    check_val("seq_x8_re", got_r[8], -27);
    check_val("seq_x8_im", got_i[8], 0);
`endif

    // Same sequence with idle gaps and full-scale junk while busy
    send_frame(2, 1'b1);
    wait_free(1'b1);
    valid_in = 1'b0;
    wait_bursts(4);
    check_val("gap_latency", int'((t_first - t_last) / PER), LAT);
`ifndef FFT_STAGE_SCALE_EN
    check_val("gap_x0_re", got_r[0], 205);
    check_val("gap_x8_re", got_r[8], -27);
`endif

    // Back-to-back frames
    set_impulse;
    send_frame(0, 1'b0);
    set_dc;
    send_frame(0, 1'b0);
    wait_bursts(6);
    check_val("b2b_latency", int'((t_first - t_last) / PER), LAT);
    check_val("b2b_bursts", bursts, 6);

    repeat (4) step;
    check_val("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_r2_dif.md
Name: fft_r2_dif

Overview:
- Block-floating-free, fixed-point radix-2 decimation-in-frequency FFT of N = 2^POW complex points.
- Collects one frame of serial input samples into an internal register array.
- Computes POW in-place butterfly stages, one butterfly per clock.
- Streams the spectrum out serially in natural bin order. Sits between a sample source (ADC/front-end) and spectral post-processing.

Parameters:
- DATA_WIDTH, 16: width of signed two's-complement real/imag samples, input and output.
- POW, 4: log2 of the transform length; N = 2^POW (default 16 points).
- TW_WIDTH, 16: signed twiddle width. Format Q1.(TW_WIDTH-2): 1.0 = 2^(TW_WIDTH-2) = 16384.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  sample strobe; sink_r/sink_i are accepted when high and busy is low.
- sink_r  in  DATA_WIDTH  input sample, real part, signed.
- sink_i  in  DATA_WIDTH  input sample, imaginary part, signed.
- source_r  out  DATA_WIDTH  output bin, real part, signed, registered.
- source_i  out  DATA_WIDTH  output bin, imaginary part, signed, registered.
- valid_out  out  1  high for exactly N consecutive cycles while bins X[0..N-1] are presented.
- busy  out  1  high in CALC and OUT; input is ignored while high.

Behaviour:
- Interface: single clock domain, clk; reset rst, synchronous, active-high.
- Reset: state=LOAD, sample counter=0, butterfly/stage counters=0. source_r=0, source_i=0, valid_out=0, busy=0. Reset asserted mid-frame aborts the frame; no partial output is ever emitted.
- LOAD state:
  - Each cycle with valid_in=1 writes the sample into buf[cnt] and increments cnt.
  - Gaps (valid_in=0) are allowed; cnt holds.
  - On the N-th accepted sample (cnt=N-1), move to CALC next cycle and set busy=1.
- CALC state: POW stages s=0..POW-1, N/2 butterflies each, one per cycle. Total POW*N/2 cycles (32 for default).
  - Stage s: half = N>>(s+1). Butterfly j = 0..N/2-1 uses grp = j / half, k = j mod half, a-index p = grp*2*half + k, b-index q = p + half.
  - Twiddle W = exp(-j*2*pi*k*2^s/N), taken from a constant ROM of N/2 entries: cos and -sin, rounded to nearest in Q1.(TW_WIDTH-2).
  - DIF butterfly: buf[p] <= a + b; buf[q] <= (a - b) * W.
  - Complex multiply uses full-precision products, arithmetic right-shift by TW_WIDTH-2 (truncation), then truncation to DATA_WIDTH. Sums are computed at DATA_WIDTH+1 and then truncated to DATA_WIDTH (two's-complement wrap, no saturation).
  - Read and write of a butterfly happen in the same cycle from/to the register array.
- OUT state: N cycles, m = 0..N-1.
  - source <= buf[bitrev_POW(m)], so that bin X[m] appears in natural order; valid_out=1.
  - After m = N-1: valid_out=0, busy=0, cnt=0, return to LOAD.
  - source_r/source_i hold their last value when valid_out=0.
- Latency: if the last sample is accepted on cycle t, X[0] appears with valid_out=1 on cycle t + POW*N/2 + 1 (t+33 for default). Throughput is one frame per N + POW*N/2 + N cycles minimum.
- valid_in asserted during CALC/OUT is ignored and the data is dropped. Samples presented on the cycle the FSM returns to LOAD are accepted as sample 0 of the next frame.
- Arithmetic exactness: bins with trivial twiddles (W = 1, -j) are bit-exact. Other bins are within +/-2 LSB of the ideal DFT when no overflow occurs.

Optional Feature:
- Macro FFT_STAGE_SCALE_EN.
- Defined: every butterfly output (both a+b and (a-b)*W) is arithmetically shifted right by 1 before write-back. Final output = DFT/N, so wrap-around cannot occur for full-scale input.
- Undefined: no per-stage scaling. Output = unscaled DFT, wraps on overflow as specified above.

Test Plan:
- Reset: hold rst for 2 cycles mid-LOAD after 5 samples -> all outputs 0, busy=0. The next 16 samples form a fresh frame; only one output burst appears, for the new frame.
- Impulse, macro off: sample 0 = 1000+0j, others 0 -> all 16 bins 1000+0j (+/-2 LSB). valid_out high for exactly 16 cycles starting 33 cycles after the last sample.
- DC, macro off: all 16 samples = 100 -> X[0]=1600, X[1..15]=0 (+/-2 LSB), imag 0. Same input with FFT_STAGE_SCALE_EN: X[0]=100, others 0.
- Real sequence 12,49,2,48,70,13,5,6 then 8 zeros, imag 0 -> X[0]=205+0j and X[8]=-27+0j exactly. X[m] and X[16-m] are complex conjugates (+/-2 LSB).
- valid_in gaps and busy: insert idle cycles between input samples, and drive valid_in=1 with data 0x7FFF throughout CALC/OUT -> result identical to the gap-free frame, with the ignored samples having no effect.
- Back-to-back frames: two consecutive frames (impulse, then DC 100) -> two bursts of 16 valid_out cycles, with correct spectra for each frame.
